// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcodes and
// instruction field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_RSB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ORR  = 4'h4;
  localparam logic [3:0] OP_EOR  = 4'h5;
  localparam logic [3:0] OP_BIC  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_LDR  = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 24;
  localparam int S_BIT     = 23;
  localparam int SHIFT_MSB = 22;
  localparam int SHIFT_LSB = 20;
  localparam int RD_MSB    = 19;
  localparam int RD_LSB    = 16;
  localparam int RN_MSB    = 15;
  localparam int RN_LSB    = 12;
  localparam int RM_MSB    = 11;
  localparam int RM_LSB    = 8;
  localparam int IM_MSB    = 15;
  localparam int IM_LSB    = 0;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its neighbours (instruction memory, register
// file, ALU, data memory). Every request is held until its ack is seen on a clock edge.
interface alu_sequencer_if #(parameter int PC_WIDTH = 16);
  logic                start;
  logic                instr_req;
  logic [PC_WIDTH-1:0] instr_addr;
  logic                instr_ack;
  logic [31:0]         instr_data;
  logic [3:0]          rf_ra1;
  logic [3:0]          rf_ra2;
  logic [3:0]          rf_wa;
  logic                rf_we;
  logic                rf_wsel;
  logic                alu_en;
  logic [3:0]          alu_opcode;
  logic [3:0]          alu_cond;
  logic                alu_s;
  logic [2:0]          alu_shift;
  logic [15:0]         alu_im;
  logic                alu_cnd_met;
  logic                mem_req;
  logic                mem_we;
  logic                mem_ack;
  logic                busy;
  logic                halted;
  logic                illegal;

  modport master (
    input  start, instr_ack, instr_data, alu_cnd_met, mem_ack,
    output instr_req, instr_addr, rf_ra1, rf_ra2, rf_wa, rf_we, rf_wsel,
           alu_en, alu_opcode, alu_cond, alu_s, alu_shift, alu_im,
           mem_req, mem_we, busy, halted, illegal
  );

  modport slave (
    output start, instr_ack, instr_data, alu_cnd_met, mem_ack,
    input  instr_req, instr_addr, rf_ra1, rf_ra2, rf_wa, rf_we, rf_wsel,
           alu_en, alu_opcode, alu_cond, alu_s, alu_shift, alu_im,
           mem_req, mem_we, busy, halted, illegal
  );
endinterface

// File: rtl/alu_sequencer_instr_decode.sv
// Combinational split of the instruction register into fields and class flags.
module instr_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  cond,
  output logic [3:0]  opcode,
  output logic        s,
  output logic [2:0]  shift,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [15:0] im,
  output logic        is_alu,
  output logic        is_cmp,
  output logic        is_ldr,
  output logic        is_str,
  output logic        is_halt,
  output logic        is_nop,
  output logic        is_illegal
);
  assign cond   = ir[COND_MSB:COND_LSB];
  assign opcode = ir[OP_MSB:OP_LSB];
  assign s      = ir[S_BIT];
  assign shift  = ir[SHIFT_MSB:SHIFT_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rn     = ir[RN_MSB:RN_LSB];
  assign rm     = ir[RM_MSB:RM_LSB];
  assign im     = ir[IM_MSB:IM_LSB];

  assign is_alu     = (opcode <= OP_MOV);
  assign is_cmp     = (opcode == OP_CMP);
  assign is_ldr     = (opcode == OP_LDR);
  assign is_str     = (opcode == OP_STR);
  assign is_halt    = (opcode == OP_HALT);
  assign is_nop     = (opcode == OP_NOP);
  // 1011..1101 have no defined behaviour
  assign is_illegal = (opcode > OP_STR) && (opcode < OP_HALT);
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer driving the ALU,
// register file and data memory; owns the program counter.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.master   bus,
  output state_t            state_dbg
);
  state_t              state, state_nxt;
  logic [31:0]         ir;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_inc, ir_load;
  logic                instr_req, alu_en, mem_req, mem_we, rf_we, rf_wsel, illegal;

  logic [3:0]  cond, opcode, rd, rn, rm;
  logic        s;
  logic [2:0]  shift;
  logic [15:0] im;
  logic        is_alu, is_cmp, is_ldr, is_str, is_halt, is_nop, is_illegal;

  instr_decode u_decode (
    .ir(ir), .cond(cond), .opcode(opcode), .s(s), .shift(shift),
    .rd(rd), .rn(rn), .rm(rm), .im(im),
    .is_alu(is_alu), .is_cmp(is_cmp), .is_ldr(is_ldr), .is_str(is_str),
    .is_halt(is_halt), .is_nop(is_nop), .is_illegal(is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= bus.instr_data;
      if (pc_inc)  pc <= pc + PC_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    instr_req = 1'b0;
    alu_en    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      S_IDLE: if (bus.start) state_nxt = S_FETCH;
      S_FETCH: begin
        instr_req = 1'b1;
        if (bus.instr_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // the pulse flags the undefined opcode even when its condition fails
        illegal = is_illegal;
        if (!bus.alu_cnd_met || is_nop || is_illegal) begin
          pc_inc    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (is_alu) begin
          state_nxt = S_WRITEBACK;
        end else if (is_cmp) begin
          pc_inc    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_MEMORY;
        end
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = is_str;
        if (bus.mem_ack) begin
          if (is_ldr) begin
            state_nxt = S_WRITEBACK;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we     = 1'b1;
        rf_wsel   = is_ldr;
        pc_inc    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Field outputs come straight from IR, so they hold from the fetch ack until the next one.
  assign bus.instr_req  = instr_req;
  assign bus.instr_addr = pc;
  assign bus.rf_ra1     = rn;
  assign bus.rf_ra2     = rm;
  assign bus.rf_wa      = rd;
  assign bus.rf_we      = rf_we;
  assign bus.rf_wsel    = rf_wsel;
  assign bus.alu_en     = alu_en;
  assign bus.alu_opcode = opcode;
  assign bus.alu_cond   = cond;
  assign bus.alu_s      = s;
  assign bus.alu_shift  = shift;
  assign bus.alu_im     = im;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.busy       = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted     = (state == S_HALT);
  assign bus.illegal    = illegal;
  assign state_dbg      = state;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: plays instruction memory, data memory and ALU, and
// checks each instruction's observed behaviour against a per-instruction model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int          PW     = 16;
  localparam logic [15:0] RST_PC = 16'hFFF0;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  alu_sequencer_if #(.PC_WIDTH(PW)) bus ();

  alu_sequencer #(.PC_WIDTH(PW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cycles;
    logic [15:0] addr;
    logic [35:0] fields;
    logic [3:0]  alu_en_n;
    logic [7:0]  alu_en_at;
    logic [3:0]  we_n;
    logic [7:0]  we_at;
    logic [4:0]  wr;
    logic [7:0]  mem_n;
    logic        mem_we;
    logic [3:0]  ill_n;
    logic        halted;
    logic        overlap;
    logic        busy_low;
  } obs_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_pc;
  logic [4:0]  exp_q[$];
  logic [4:0]  got_q[$];
  localparam logic [64:0] IDLE_OUTS = {1'b0, RST_PC, 48'd0};

  function automatic logic [64:0] outs();
    return {bus.instr_req, bus.instr_addr, bus.rf_ra1, bus.rf_ra2, bus.rf_wa,
            bus.rf_we, bus.rf_wsel, bus.alu_en, bus.alu_opcode, bus.alu_cond,
            bus.alu_s, bus.alu_shift, bus.alu_im, bus.mem_req, bus.mem_we,
            bus.busy, bus.halted, bus.illegal};
  endfunction

  // Expected behaviour of one instruction from FETCH entry to the next FETCH entry (or HALT).
  function automatic obs_t model(input logic [31:0] ins, input logic cnd,
                                 input int fw, input int mw, input logic [15:0] pc);
    obs_t       e;
    logic [3:0] op;
    logic       undef;
    e     = '0;
    op    = ins[27:24];
    undef = (op >= 4'd11) && (op <= 4'd13);
    e.addr   = pc;
    e.fields = {ins[31:28], ins[27:24], ins[23], ins[22:20], ins[15:0], ins[15:12], ins[11:8]};
    e.ill_n  = undef ? 4'd1 : 4'd0;
    if (!cnd || op == 4'd15 || undef) begin
      e.cycles = 8'(fw + 2);
    end else if (op == 4'd14) begin
      e.cycles = 8'(fw + 2);
      e.halted = 1'b1;
    end else begin
      e.alu_en_n  = 4'd1;
      e.alu_en_at = 8'(fw + 3);
      if (op < 4'd8) begin
        e.cycles = 8'(fw + 4);
        e.we_n   = 4'd1;
        e.we_at  = 8'(fw + 4);
        e.wr     = {1'b0, ins[19:16]};
      end else if (op == 4'd8) begin
        e.cycles = 8'(fw + 3);
      end else begin
        e.mem_n  = 8'(mw + 1);
        e.mem_we = (op == 4'd10);
        if (op == 4'd9) begin
          e.cycles = 8'(fw + mw + 5);
          e.we_n   = 4'd1;
          e.we_at  = 8'(fw + mw + 5);
          e.wr     = {1'b1, ins[19:16]};
        end else begin
          e.cycles = 8'(fw + mw + 4);
        end
      end
    end
    return e;
  endfunction

  // Called at the falling edge of a FETCH entry cycle; returns at the falling
  // edge of the next FETCH entry cycle, or of the first HALT cycle.
  task automatic run_instr(input logic [31:0] ins, input logic cnd, input int fw,
                           input int mw, output obs_t o);
    int   k, fc, mc, fdone;
    logic fetched, done;
    o = '0; fc = 0; mc = 0; fdone = 0; fetched = 1'b0; done = 1'b0; k = 1;
    while (!done && k <= 60) begin
      if (k > 1 && ((fetched && bus.instr_req) || bus.halted)) begin
        o.cycles = 8'(k - 1);
        o.halted = bus.halted;
        done     = 1'b1;
      end else begin
        if (k == 1) o.addr = bus.instr_addr;
        if (fetched && k == fdone + 1)
          o.fields = {bus.alu_cond, bus.alu_opcode, bus.alu_s, bus.alu_shift,
                      bus.alu_im, bus.rf_ra1, bus.rf_ra2};
        if (bus.alu_en) begin
          o.alu_en_n = o.alu_en_n + 4'd1;
          if (o.alu_en_at == 8'd0) o.alu_en_at = 8'(k);
        end
        if (bus.rf_we) begin
          o.we_n  = o.we_n + 4'd1;
          o.we_at = 8'(k);
          o.wr    = {bus.rf_wsel, bus.rf_wa};
          got_q.push_back({bus.rf_wsel, bus.rf_wa});
        end
        if (bus.mem_req) begin
          o.mem_n  = o.mem_n + 8'd1;
          o.mem_we = o.mem_we | bus.mem_we;
        end
        if (bus.illegal) o.ill_n = o.ill_n + 4'd1;
        if (bus.instr_req && bus.mem_req) o.overlap = 1'b1;
        if (!bus.busy) o.busy_low = 1'b1;
        bus.alu_cnd_met = cnd;
        if (bus.instr_req) begin
          bus.instr_ack  = (fc == fw);
          bus.instr_data = (fc == fw) ? ins : $urandom;
          if (fc == fw) begin fetched = 1'b1; fdone = k; end
          fc++;
        end else begin
          bus.instr_ack  = 1'($urandom_range(0, 1));
          bus.instr_data = $urandom;
        end
        if (bus.mem_req) begin
          bus.mem_ack = (mc == mw);
          mc++;
        end else begin
          bus.mem_ack = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    if (!done) o.cycles = 8'hFF;
    bus.instr_ack = 1'b0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (outs() !== IDLE_OUTS) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", outs(), IDLE_OUTS);
    end
    total++;
    if (state_dbg !== S_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE);
    end
    reset = 1'b0;
    model_pc = RST_PC;
  endtask

  task automatic test_start();
    for (int i = 0; i < 4; i++) begin
      bus.instr_ack = 1'($urandom_range(0, 1));
      bus.mem_ack   = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    bus.instr_ack = 1'b0;
    bus.mem_ack   = 1'b0;
    total++;
    if (outs() !== IDLE_OUTS || state_dbg !== S_IDLE) begin
      bad++; $display("FAIL idle_without_start: got %h want %h", outs(), IDLE_OUTS);
    end
    go();
    total++;
    if (state_dbg !== S_FETCH || bus.instr_req !== 1'b1 || bus.instr_addr !== RST_PC) begin
      bad++; $display("FAIL start_fetch: state %0d req %b addr %h want fetch req 1 addr %h",
                      state_dbg, bus.instr_req, bus.instr_addr, RST_PC);
    end
  endtask

  task automatic test_add();
    obs_t o, e;
    e = model(32'hE0031200, 1'b1, 0, 0, model_pc);
    run_instr(32'hE0031200, 1'b1, 0, 0, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e) begin bad++; $display("FAIL add_model: got %h want %h", o, e); end
    total++;
    if (o.alu_en_at !== 8'd3 || o.we_at !== 8'd4 || o.wr !== 5'd3) begin
      bad++; $display("FAIL add_timing: alu_en@%0d we@%0d wr %h want 3 4 03",
                      o.alu_en_at, o.we_at, o.wr);
    end
    total++;
    if (bus.instr_addr !== model_pc) begin
      bad++; $display("FAIL add_pc: got %h want %h", bus.instr_addr, model_pc);
    end
  endtask

  task automatic test_ldr();
    obs_t o, e;
    e = model(32'hE9052000, 1'b1, 0, 3, model_pc);
    run_instr(32'hE9052000, 1'b1, 0, 3, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e) begin bad++; $display("FAIL ldr_model: got %h want %h", o, e); end
    total++;
    if (o.mem_n !== 8'd4 || o.mem_we !== 1'b0 || o.wr !== 5'h15) begin
      bad++; $display("FAIL ldr_mem: mem_n %0d we %b wr %h want 4 0 15", o.mem_n, o.mem_we, o.wr);
    end
  endtask

  task automatic test_cond_fail();
    obs_t o, e;
    e = model(32'h00031200, 1'b0, 0, 0, model_pc);
    run_instr(32'h00031200, 1'b0, 0, 0, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e) begin bad++; $display("FAIL cond_fail_model: got %h want %h", o, e); end
    total++;
    if (o.cycles !== 8'd2 || o.alu_en_n !== 4'd0 || o.we_n !== 4'd0 || bus.instr_addr !== model_pc) begin
      bad++; $display("FAIL cond_fail: cycles %0d alu_en %0d we %0d addr %h want 2 0 0 %h",
                      o.cycles, o.alu_en_n, o.we_n, bus.instr_addr, model_pc);
    end
  endtask

  task automatic test_cmp_str_illegal();
    obs_t o, e;
    e = model(32'hE8012300, 1'b1, 0, 0, model_pc);
    run_instr(32'hE8012300, 1'b1, 0, 0, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e || o.we_n !== 4'd0) begin bad++; $display("FAIL cmp: got %h want %h", o, e); end
    e = model(32'hEA032000, 1'b1, 1, 1, model_pc);
    run_instr(32'hEA032000, 1'b1, 1, 1, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e || o.mem_we !== 1'b1 || o.we_n !== 4'd0) begin
      bad++; $display("FAIL str: got %h want %h", o, e);
    end
    e = model(32'hEC000000, 1'b1, 0, 0, model_pc);
    run_instr(32'hEC000000, 1'b1, 0, 0, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e || o.ill_n !== 4'd1) begin bad++; $display("FAIL illegal: got %h want %h", o, e); end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic [31:0] ins;
    logic        cnd;
    int          fw, mw;
    logic [4:0]  w;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      if (ins[27:24] == 4'hE) ins[27:24] = 4'hF;
      cnd = 1'($urandom_range(0, 1));
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      e = model(ins, cnd, fw, mw, model_pc);
      if (e.we_n != 4'd0) exp_q.push_back(e.wr);
      run_instr(ins, cnd, fw, mw, o);
      model_pc = model_pc + 16'd1;
      total++;
      if (o !== e) begin
        bad++; $display("FAIL random[%0d] ins %h cnd %b: got %h want %h", i, ins, cnd, o, e);
      end
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_writes: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front();
      total++;
      if (got_q[0] !== w) begin bad++; $display("FAIL random_wr: got %h want %h", got_q[0], w); end
      void'(got_q.pop_front());
    end
  endtask

  task automatic test_reset_in_memory();
    bus.alu_cnd_met = 1'b1;
    bus.instr_ack   = 1'b1;
    bus.instr_data  = 32'hEA012000;
    @(posedge clk); @(negedge clk);
    bus.instr_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL mem_req_before_reset: got %b want 1", bus.mem_req); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    total++;
    if (outs() !== IDLE_OUTS || state_dbg !== S_IDLE) begin
      bad++; $display("FAIL reset_in_memory: got %h want %h", outs(), IDLE_OUTS);
    end
    bus.mem_ack   = 1'b1;
    bus.instr_ack = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    bus.mem_ack   = 1'b0;
    bus.instr_ack = 1'b0;
    total++;
    if (outs() !== IDLE_OUTS || state_dbg !== S_IDLE) begin
      bad++; $display("FAIL late_ack_ignored: got %h want %h", outs(), IDLE_OUTS);
    end
    model_pc = RST_PC;
  endtask

  task automatic test_wrap_halt();
    obs_t o, e;
    go();
    for (int i = 0; i < 15; i++) begin
      run_instr(32'hEF000000, 1'b1, 0, 0, o);
      model_pc = model_pc + 16'd1;
    end
    e = model(32'hEF000000, 1'b1, 0, 0, model_pc);
    run_instr(32'hEF000000, 1'b1, 0, 0, o);
    model_pc = model_pc + 16'd1;
    total++;
    if (o !== e || o.addr !== 16'hFFFF || bus.instr_addr !== 16'h0000) begin
      bad++; $display("FAIL pc_wrap: from %h to %h want FFFF to 0000", o.addr, bus.instr_addr);
    end
    e = model(32'hEE000000, 1'b1, 0, 0, model_pc);
    run_instr(32'hEE000000, 1'b1, 0, 0, o);
    total++;
    if (o !== e || bus.halted !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL halt: got %h halted %b busy %b want %h 1 0", o, bus.halted, bus.busy, e);
    end
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.instr_ack = 1'($urandom_range(0, 1));
      bus.mem_ack   = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
    end
    bus.start = 1'b0; bus.instr_ack = 1'b0; bus.mem_ack = 1'b0;
    total++;
    if (state_dbg !== S_HALT || bus.halted !== 1'b1 || bus.instr_req !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL halt_absorbing: state %0d halted %b req %b busy %b",
                      state_dbg, bus.halted, bus.instr_req, bus.busy);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    total++;
    if (outs() !== IDLE_OUTS || state_dbg !== S_IDLE) begin
      bad++; $display("FAIL reset_from_halt: got %h want %h", outs(), IDLE_OUTS);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.instr_ack   = 1'b0;
    bus.instr_data  = 32'd0;
    bus.alu_cnd_met = 1'b0;
    bus.mem_ack     = 1'b0;
    test_reset();
    test_start();
    test_add();
    test_ldr();
    test_cond_fail();
    test_cmp_str_illegal();
    test_random();
    test_reset_in_memory();
    test_wrap_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that drives the 32-bit ALU block: it fetches one 32-bit instruction, decodes its fields, drives register-file read ports and the ALU control inputs, and pulses the ALU enable. It then steps through data-memory access and register write-back. It sits between instruction memory, the register file, the ALU and data memory, and owns the program counter.

## Interface
- PC_WIDTH, 16, program counter / instruction address width (word addressed)
- RESET_PC, 0, PC value loaded on reset
---
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  leaves IDLE when high
- INSTR_REQ  out  1  instruction fetch request
- INSTR_ADDR  out  PC_WIDTH  current PC
- INSTR_ACK  in  1  fetch data valid this cycle
- INSTR_DATA  in  32  fetched instruction
- RF_RA1, RF_RA2  out  4  read addresses (SR1, SR2)
- RF_WA  out  4  write address
- RF_WE  out  1  register write strobe
- RF_WSEL  out  1  0 = ALU result, 1 = memory read data
- ALU_EN  out  1  ALU enable; the ALU captures on its rising edge
- ALU_OPCODE, ALU_COND  out  4  opcode and condition
- ALU_S  out  1  flag-set bit
- ALU_SHIFT  out  3  SHIFT_ROR_CTRL
- ALU_IM  out  16  immediate
- ALU_CND_MET  in  1  ALU condition-met output
- MEM_REQ  out  1  data memory request; the address is the ALU result
- MEM_WE  out  1  1 = store, 0 = load
- MEM_ACK  in  1  data memory complete
- BUSY  out  1  high in any state except IDLE and HALT
- HALTED  out  1  high in HALT
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode

## Operation
- Instruction fields:
  - [31:28] COND
  - [27:24] OPCODE
  - [23] S
  - [22:20] SHIFT
  - [19:16] RD
  - [15:12] RN to RA1
  - [11:8] RM to RA2
  - [15:0] IM, with shift amount in IM[7:3]
- Opcodes:
  - 0000–0111: ALU op with write-back
  - 1000: CMP (no write-back)
  - 1001: LDR
  - 1010: STR
  - 1110: HALT
  - 1111: NOP
  - 1011–1101: illegal, executed as NOP with an ILLEGAL pulse
- States and transitions:
  - IDLE → FETCH when START=1.
  - FETCH: INSTR_REQ=1, held until INSTR_ACK. On ACK, latch INSTR_DATA into IR and go to DECODE.
  - DECODE: ALU_*, RF_RA1 and RF_RA2 are driven from IR; they are registered from IR and stay stable until the next FETCH. Sample ALU_CND_MET.
    - If not met, or the opcode is NOP/illegal: PC+1, go to FETCH.
    - If HALT: go to HALT.
    - Otherwise go to EXECUTE.
  - EXECUTE: ALU_EN=1 for exactly one cycle.
    - ALU op → WRITEBACK.
    - CMP → FETCH with PC+1.
    - LDR/STR → MEMORY.
  - MEMORY: MEM_REQ=1, with MEM_WE=1 for STR, held until MEM_ACK.
    - LDR → WRITEBACK with RF_WSEL=1.
    - STR → FETCH with PC+1.
  - WRITEBACK: RF_WE=1 for one cycle, RF_WA=RD. PC+1, go to FETCH.
  - HALT: absorbing; only RESET leaves it.
- PC increments modulo 2^PC_WIDTH; it wraps from all-ones to 0.

## Timing
- Reset values:
  - state IDLE, PC=RESET_PC, IR=0
  - every output 0, including INSTR_ADDR=RESET_PC
- RESET in any state takes priority on the same edge. Outstanding requests drop on the next cycle. A late INSTR_ACK or MEM_ACK arriving in IDLE is ignored.
- An ACK arriving in a state that does not request is ignored.
- With zero-wait memory (ACK in the first request cycle), cycles from FETCH entry to the next FETCH entry are:
  - ALU op: 4
  - CMP: 3
  - LDR: 5
  - STR: 4
  - condition-fail/NOP: 2
- ALU_EN rises one cycle after the fields become valid, so setup to the ALU is always at least one full cycle.
- RF_WE and ALU_EN never exceed one cycle high.
- INSTR_REQ and MEM_REQ are never high together.

## Structure
- Package alu_seq_pkg holds:
  - state enum
  - opcode constants (OP_ADD…OP_STR, OP_HALT, OP_NOP)
  - instruction field bit positions
- Sub-module instr_decode: combinational. It takes IR and outputs the split fields plus class flags: is_alu, is_cmp, is_ldr, is_str, is_halt, is_nop, is_illegal.

## Test plan
- RESET, then START with ADD R3,R1,R2 (0xE0031200, COND=always) and zero-wait ACKs → ALU_EN pulses in cycle 3, RF_WE=1 with RF_WA=3 in cycle 4, INSTR_ADDR goes 0→1.
- LDR R5,[R2] with MEM_ACK delayed 3 cycles → MEM_REQ held 4 cycles with MEM_WE=0; RF_WE then fires with RF_WSEL=1, RF_WA=5.
- Instruction whose condition fails (ALU_CND_MET=0) → no ALU_EN, no RF_WE, next FETCH 2 cycles later, PC+1.
- CMP, STR and opcode 1100 in sequence → CMP has no RF_WE; STR gives MEM_WE=1 and no RF_WE; 1100 gives a one-cycle ILLEGAL pulse and continues.
- RESET asserted during MEMORY with MEM_REQ high → next cycle IDLE, all outputs 0, PC=RESET_PC; a later MEM_ACK changes nothing.
- PC=0xFFFF executing NOP → PC wraps to 0x0000. Then HALT → HALTED=1, BUSY=0, START ignored until RESET.
